// File: rtl/delay_scheduler.sv
// delay_scheduler: shared delay timer for the BlackJack game FSMs.
// A free-running prescaler produces a tick strobe; one down-counter is
// time-multiplexed round-robin among three requesters, each of which gets a
// one-cycle completion pulse when its delay of N ticks has elapsed.
module delay_scheduler #(
    parameter int CLK_DIV = 25000,
    parameter int WIDTH   = 12
) (
    input  logic                 clk_50M,
    input  logic                 i_Reset,
    input  logic [2:0]           i_Req,
    input  logic [3*WIDTH-1:0]   i_Dur,
    input  logic                 i_Abort,
    output logic [2:0]           o_Grant,
    output logic [2:0]           o_Done,
    output logic                 o_Busy,
    output logic [WIDTH-1:0]     o_Remaining,
    output logic                 o_Tick
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t            state_reg;
    logic [PW-1:0]     presc_reg;
    logic [2:0]        grant_reg;
    logic [2:0]        done_reg;
    logic              busy_reg;
    logic [WIDTH-1:0]  remaining_reg;
    logic [1:0]        last_reg;
    logic [1:0]        owner_reg;

    logic              tick;
    logic [WIDTH-1:0]  dur_arr [3];
    logic              win_valid;
    logic [1:0]        win_idx;
    logic [2:0]        win_onehot;
    logic [WIDTH-1:0]  win_dur;
    logic [2:0]        rr_sum;
    logic              owner_req;

    // Unpack the per-requester duration fields.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dur
            assign dur_arr[gi] = i_Dur[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Tick is a pure decode of the prescaler, independent of FSM state.
    assign tick = (presc_reg == PW'(CLK_DIV - 1));

    // The owner keeps the counter only while it still holds its request.
    assign owner_req = |(i_Req & grant_reg);

    // Free-running prescaler 0..CLK_DIV-1.
    always_ff @(posedge clk_50M) begin
        if (i_Reset) begin
            presc_reg <= '0;
        end else if (tick) begin
            presc_reg <= '0;
        end else begin
            presc_reg <= presc_reg + 1'b1;
        end
    end

    // Round-robin winner: scan offsets 3..1 so the nearest (last+1) wins.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = 2'd0;
        rr_sum    = 3'd0;
        for (int off = 3; off >= 1; off--) begin
            rr_sum = {1'b0, last_reg} + 3'(off);
            if (rr_sum >= 3'd3) begin
                rr_sum = rr_sum - 3'd3;
            end
            if (i_Req[rr_sum[1:0]]) begin
                win_valid = 1'b1;
                win_idx   = rr_sum[1:0];
            end
        end
    end

    // Duration and one-hot grant for the selected winner.
    always_comb begin
        win_onehot = 3'b001 << win_idx;
        case (win_idx)
            2'd0:    win_dur = dur_arr[0];
            2'd1:    win_dur = dur_arr[1];
            2'd2:    win_dur = dur_arr[2];
            default: win_dur = '0;
        endcase
    end

    // Arbitration / countdown FSM with registered outputs.
    always_ff @(posedge clk_50M) begin
        if (i_Reset) begin
            state_reg     <= ST_IDLE;
            grant_reg     <= 3'b000;
            done_reg      <= 3'b000;
            busy_reg      <= 1'b0;
            remaining_reg <= '0;
            last_reg      <= 2'd2;
            owner_reg     <= 2'd0;
        end else begin
            done_reg <= 3'b000;
            case (state_reg)
                ST_IDLE: begin
                    if (win_valid) begin
                        remaining_reg <= win_dur;
                        grant_reg     <= win_onehot;
                        owner_reg     <= win_idx;
                        busy_reg      <= 1'b1;
                        state_reg     <= ST_RUN;
                    end else begin
                        remaining_reg <= '0;
                    end
                end
                ST_RUN: begin
                    if (i_Abort || !owner_req) begin
                        // Cancelled or withdrawn: release silently.
                        grant_reg     <= 3'b000;
                        remaining_reg <= '0;
                        busy_reg      <= 1'b0;
                        last_reg      <= owner_reg;
                        state_reg     <= ST_IDLE;
                    end else if (remaining_reg == '0) begin
                        done_reg  <= grant_reg;
                        grant_reg <= 3'b000;
                        state_reg <= ST_DONE;
                    end else if (tick) begin
                        remaining_reg <= remaining_reg - 1'b1;
                    end
                end
                ST_DONE: begin
                    busy_reg  <= 1'b0;
                    last_reg  <= owner_reg;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_Grant     = grant_reg;
    assign o_Done      = done_reg;
    assign o_Busy      = busy_reg;
    assign o_Remaining = remaining_reg;
    assign o_Tick      = tick;

endmodule

// File: tb/tb_delay_scheduler.sv
// Testbench for delay_scheduler (CLK_DIV=4, WIDTH=12). Completion pulses are
// checked by a scoreboard monitor; grant/remaining/tick by directed checks.
module tb_delay_scheduler;

    localparam int W = 12;

    logic           clk_50M = 1'b0;
    logic           i_Reset;
    logic [2:0]     i_Req;
    logic [3*W-1:0] i_Dur;
    logic           i_Abort;
    logic [2:0]     o_Grant;
    logic [2:0]     o_Done;
    logic           o_Busy;
    logic [W-1:0]   o_Remaining;
    logic           o_Tick;

    delay_scheduler #(.CLK_DIV(4), .WIDTH(W)) dut (
        .clk_50M     (clk_50M),
        .i_Reset     (i_Reset),
        .i_Req       (i_Req),
        .i_Dur       (i_Dur),
        .i_Abort     (i_Abort),
        .o_Grant     (o_Grant),
        .o_Done      (o_Done),
        .o_Busy      (o_Busy),
        .o_Remaining (o_Remaining),
        .o_Tick      (o_Tick)
    );

    always #5 clk_50M = ~clk_50M;

    typedef struct {
        logic [2:0] done;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   pc       = 0;

    // Cycle stamp and bench-side prescaler phase model.
    always @(posedge clk_50M) begin
        cyc <= cyc + 1;
        if (i_Reset) pc <= 0;
        else         pc <= (pc + 1) % 4;
    end

    // Scoreboard monitor: every completion pulse must match the queue head.
    always @(negedge clk_50M) begin
        if (!i_Reset && o_Done != 3'b000) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_done act=%b at cycle %0d, none expected", o_Done, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if (o_Done === mon_e.done && (mon_e.cyc < 0 || mon_e.cyc == cyc)) begin
                    n_pass++;
                    $display("done %b at cycle %0d ok", o_Done, cyc);
                end else begin
                    $display("FAIL done_pulse act=%b@%0d req=%b@%0d", o_Done, cyc, mon_e.done, mon_e.cyc);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_50M);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s act=%0d req=%0d at cycle %0d", nm, act, req, cyc);
    endtask

    task automatic push(input logic [2:0] d, input int c);
        exp_t e;
        e.done = d;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic wait_state(input logic [W-1:0] r, input logic [2:0] g, input string nm);
        bit found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (o_Remaining == r && o_Grant == g) found = 1;
            else step();
        end
        chk(nm, 32'(found), 32'd1);
    endtask

    task automatic wait_done_drop(input int k);
        bit found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (o_Done[k]) begin
                i_Req[k] = 1'b0;
                found = 1;
            end else begin
                step();
            end
        end
        chk($sformatf("wait_done_%0d", k), 32'(found), 32'd1);
    endtask

    task automatic align();
        for (int i = 0; i < 4 && pc != 0; i++) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        i_Reset = 1'b1;
        i_Req   = 3'b000;
        i_Dur   = '0;
        i_Abort = 1'b0;

        // Reset: 3 cycles held, then outputs zero and tick every 4th cycle.
        step(); step(); step();
        i_Reset = 1'b0;
        chk("rst_grant", 32'(o_Grant), 0);
        chk("rst_done", 32'(o_Done), 0);
        chk("rst_busy", 32'(o_Busy), 0);
        chk("rst_rem", 32'(o_Remaining), 0);
        for (int i = 1; i <= 12; i++) begin
            chk($sformatf("rst_tick_c%0d", i), 32'(o_Tick), 32'(i % 4 == 0));
            step();
        end
        $display("reset sequence done");

        // Round-robin: 111 served 0,1,2.
        i_Dur = {12'd1, 12'd1, 12'd1};
        push(3'b001, -1); push(3'b010, -1); push(3'b100, -1);
        i_Req = 3'b111;
        wait_done_drop(0);
        wait_done_drop(1);
        wait_done_drop(2);
        step();
        // last=2: 0 before 1.
        push(3'b001, -1); push(3'b010, -1);
        i_Req = 3'b011;
        wait_done_drop(0);
        wait_done_drop(1);
        step();
        // last=1: 2 before 0.
        push(3'b100, -1); push(3'b001, -1);
        i_Req = 3'b101;
        wait_done_drop(2);
        wait_done_drop(0);
        step();
        $display("round-robin sequence done");

        // Single delay of 3 ticks, started on prescaler phase 0.
        align();
        a = cyc;
        i_Dur[0 +: W] = 12'd3;
        i_Req = 3'b001;
        push(3'b001, a + 13);
        for (int j = 1; j <= 14; j++) begin
            step();
            chk($sformatf("single_rem_j%0d", j), 32'(o_Remaining),
                (j <= 3) ? 3 : (j <= 7) ? 2 : (j <= 11) ? 1 : 0);
            chk($sformatf("single_grant_j%0d", j), 32'(o_Grant), (j <= 12) ? 1 : 0);
            chk($sformatf("single_busy_j%0d", j), 32'(o_Busy), (j <= 13) ? 1 : 0);
            if (j == 3 || j == 7 || j == 11) chk($sformatf("single_tick_j%0d", j), 32'(o_Tick), 1);
            if (j == 13) i_Req = 3'b000;
        end
        $display("single delay done");

        // Zero duration on requester 1: done at request edge + 2, no tick.
        align();
        a = cyc;
        i_Dur[W +: W] = 12'd0;
        i_Req = 3'b010;
        push(3'b010, a + 2);
        step();
        chk("zero_grant", 32'(o_Grant), 32'b010);
        chk("zero_rem", 32'(o_Remaining), 0);
        chk("zero_notick", 32'(o_Tick), 0);
        step();
        i_Req = 3'b000;
        chk("zero_grant_fall", 32'(o_Grant), 0);
        chk("zero_busy_done", 32'(o_Busy), 1);
        step();
        chk("zero_busy_idle", 32'(o_Busy), 0);
        $display("zero duration done");

        // Abort requester 0 at remaining 3; pending requester 1 follows.
        i_Dur = {12'd0, 12'd2, 12'd5};
        i_Req = 3'b011;
        wait_state(12'd3, 3'b001, "abort_wait");
        i_Abort = 1'b1;
        step();
        i_Abort = 1'b0;
        chk("abort_grant", 32'(o_Grant), 0);
        chk("abort_rem", 32'(o_Remaining), 0);
        chk("abort_busy", 32'(o_Busy), 0);
        step();
        chk("abort_next_grant", 32'(o_Grant), 32'b010);
        chk("abort_next_rem", 32'(o_Remaining), 2);
        i_Req = 3'b000;
        step();
        chk("withdraw1_grant", 32'(o_Grant), 0);
        $display("abort done");

        // Same with requester 0 withdrawing instead of abort.
        i_Req = 3'b011;
        wait_state(12'd3, 3'b001, "withdraw_wait");
        i_Req = 3'b010;
        step();
        chk("withdraw_grant", 32'(o_Grant), 0);
        chk("withdraw_rem", 32'(o_Remaining), 0);
        step();
        chk("withdraw_next_grant", 32'(o_Grant), 32'b010);
        chk("withdraw_next_rem", 32'(o_Remaining), 2);
        i_Req = 3'b000;
        step();
        chk("withdraw_idle", 32'(o_Grant), 0);
        $display("withdraw done");

        // Reset mid-run at remaining 5 (last=1 before reset).
        i_Dur[0 +: W] = 12'd7;
        i_Req = 3'b001;
        wait_state(12'd5, 3'b001, "midrst_wait");
        i_Reset = 1'b1;
        i_Req   = 3'b000;
        step();
        i_Reset = 1'b0;
        chk("midrst_grant", 32'(o_Grant), 0);
        chk("midrst_rem", 32'(o_Remaining), 0);
        chk("midrst_busy", 32'(o_Busy), 0);
        chk("midrst_done", 32'(o_Done), 0);
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("midrst_tick_c%0d", i), 32'(o_Tick), 32'(i == 4));
            step();
        end
        // Requester 0 must win over 2 after reset.
        i_Dur = {12'd0, 12'd0, 12'd0};
        a = cyc;
        i_Req = 3'b101;
        push(3'b001, a + 2);
        push(3'b100, a + 5);
        step();
        chk("midrst_first_grant", 32'(o_Grant), 32'b001);
        step();
        i_Req = 3'b100;
        step();
        step();
        chk("midrst_second_grant", 32'(o_Grant), 32'b100);
        step();
        i_Req = 3'b000;
        step();
        chk("midrst_end_busy", 32'(o_Busy), 0);
        step();
        $display("reset mid-run done");

        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL missing_done act=%0d pending req=0 pending", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
